// File: rtl/mmu_sequencer.sv
// rtl/mmu_sequencer.sv - tile scheduler: weight load then activation streaming through the MMU
// Optional weight reuse (skip LOAD_W) enabled by defining MMU_SEQ_WEIGHT_REUSE_EN.
module mmu_sequencer #(
  parameter int ARRAY_DIM  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MMU_LAT    = 31,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] wb_base,
  input  logic [ADDR_WIDTH-1:0] ub_base,
  input  logic [ADDR_WIDTH-1:0] acc_base,
  input  logic [ADDR_WIDTH-1:0] num_rows,
  input  logic                  accumulate,
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
  input  logic                  reuse_w,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  read_wb,
  output logic                  read_ub,
  output logic                  weight_fifo_en,
  output logic                  data_fifo_en,
  output logic                  mmu_load_weight_en,
  output logic                  mm_en,
  output logic                  write_acc,
  output logic                  acc_en,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr
);

  localparam int CW = ADDR_WIDTH + 7;
  localparam logic [CW-1:0]         WLOAD_LAST = CW'(ARRAY_DIM + FIFO_DEPTH);
  localparam logic [CW-1:0]         AD         = CW'(ARRAY_DIM);
  localparam logic [CW-1:0]         W0         = CW'(1 + FIFO_DEPTH + MMU_LAT);
  localparam logic [ADDR_WIDTH-1:0] W0_A       = ADDR_WIDTH'(1 + FIFO_DEPTH + MMU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_EXEC, S_DONE} state_t;

  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [ADDR_WIDTH-1:0] r_wb_base, r_ub_base, r_acc_base, r_num_rows;
  logic                  r_accumulate;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_wb, w_ub, w_acc, w_num;
  logic                  w_accum;
  logic [CW-1:0]         w_n_ext;
  logic                  w_rd_w, w_rd_u, w_wr;
  logic [ADDR_WIDTH-1:0] w_wr_off;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
  logic                  r_reuse_w, w_reuse;
`endif

  // Outputs are registered from the next state so they line up with the state they describe;
  // that means the first cycle after start must already see the freshly latched bases.
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_wb     = w_accept ? wb_base    : r_wb_base;
  assign w_ub     = w_accept ? ub_base    : r_ub_base;
  assign w_acc    = w_accept ? acc_base   : r_acc_base;
  assign w_num    = w_accept ? num_rows   : r_num_rows;
  assign w_accum  = w_accept ? accumulate : r_accumulate;
  assign w_n_ext  = CW'(w_num);
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
  assign w_reuse  = w_accept ? reuse_w : r_reuse_w;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (num_rows == '0) begin
            w_state_nx = S_DONE;
          end else begin
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
            w_state_nx = w_reuse ? S_EXEC : S_LOAD_W;
`else
            w_state_nx = S_LOAD_W;
`endif
          end
        end
      end
      S_LOAD_W: begin
        if (r_cnt == WLOAD_LAST) w_state_nx = S_EXEC;
        else                     w_cnt_nx   = r_cnt + 1'b1;
      end
      S_EXEC: begin
        if (r_cnt == w_n_ext + W0 - 1'b1) w_state_nx = S_DONE;
        else                              w_cnt_nx   = r_cnt + 1'b1;
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_rd_w   = (w_state_nx == S_LOAD_W) && (w_cnt_nx < AD);
  assign w_rd_u   = (w_state_nx == S_EXEC) && (w_cnt_nx < w_n_ext);
  assign w_wr     = (w_state_nx == S_EXEC) && (w_cnt_nx >= W0) && (w_cnt_nx < W0 + w_n_ext);
  assign w_wr_off = w_cnt_nx[ADDR_WIDTH-1:0] - W0_A;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_wb_base          <= '0;
      r_ub_base          <= '0;
      r_acc_base         <= '0;
      r_num_rows         <= '0;
      r_accumulate       <= 1'b0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      r_reuse_w          <= 1'b0;
`endif
      busy               <= 1'b0;
      done               <= 1'b0;
      read_wb            <= 1'b0;
      read_ub            <= 1'b0;
      weight_fifo_en     <= 1'b0;
      data_fifo_en       <= 1'b0;
      mmu_load_weight_en <= 1'b0;
      mm_en              <= 1'b0;
      write_acc          <= 1'b0;
      acc_en             <= 1'b0;
      addr_rd            <= '0;
      addr_wr            <= '0;
    end else begin
      r_state            <= w_state_nx;
      r_cnt              <= w_cnt_nx;
      r_wb_base          <= w_wb;
      r_ub_base          <= w_ub;
      r_acc_base         <= w_acc;
      r_num_rows         <= w_num;
      r_accumulate       <= w_accum;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      r_reuse_w          <= w_reuse;
`endif
      busy               <= (w_state_nx != S_IDLE);
      done               <= (w_state_nx == S_DONE);
      read_wb            <= w_rd_w;
      read_ub            <= w_rd_u;
      weight_fifo_en     <= (w_state_nx == S_LOAD_W);
      mmu_load_weight_en <= (w_state_nx == S_LOAD_W);
      data_fifo_en       <= (w_state_nx == S_EXEC);
      mm_en              <= (w_state_nx == S_EXEC);
      write_acc          <= w_wr;
      acc_en             <= w_wr && w_accum;
      addr_rd            <= w_rd_w ? (w_wb + w_cnt_nx[ADDR_WIDTH-1:0]) :
                            w_rd_u ? (w_ub + w_cnt_nx[ADDR_WIDTH-1:0]) : '0;
      addr_wr            <= w_wr ? (w_acc + w_wr_off) : '0;
    end
  end

endmodule

// File: doc/mmu_sequencer.md
# mmu_sequencer

Tile-level scheduler for the systolic-array datapath. On a single `start`, it does two things in a fixed, cycle-exact order. First it loads one ARRAY_DIM×ARRAY_DIM weight tile from the weight buffer through the weight FIFO into the matrix-multiply unit. Then it streams `num_rows` activation rows from the unified buffer through the data FIFO and the MMU, and writes each result row into the accumulator. It sits between the control unit (which supplies base addresses and row count) and the buffer/FIFO/MMU/accumulator strobes, replacing per-cycle strobe generation in the control unit.

## Interface
Parameters:
- ARRAY_DIM, 16, MMU rows/columns; also the number of weight rows loaded per tile.
- FIFO_DEPTH, 4, latency in cycles of the weight and data FIFOs.
- MMU_LAT, 31, cycles from a data-FIFO output row entering the MMU to its result on the MMU output.
- ADDR_WIDTH, 8, width of all buffer and accumulator addresses.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- wb_base  in  ADDR_WIDTH  first weight-buffer row.
- ub_base  in  ADDR_WIDTH  first unified-buffer row.
- acc_base  in  ADDR_WIDTH  first accumulator row.
- num_rows  in  ADDR_WIDTH  activation rows N to stream; 0 is legal.
- accumulate  in  1  1 = add into accumulator, 0 = overwrite.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- read_wb, read_ub  out  1  buffer read enables (1-cycle BRAM read latency).
- weight_fifo_en, data_fifo_en  out  1  FIFO shift enables.
- mmu_load_weight_en, mm_en  out  1  MMU weight-load and compute enables.
- write_acc, acc_en  out  1  accumulator write and accumulate-mode strobes.
- addr_rd  out  ADDR_WIDTH  read address (WB or UB, port B).
- addr_wr  out  ADDR_WIDTH  accumulator write address (port A).

## Operation
- States: IDLE → LOAD_W → EXEC → DONE → IDLE. One counter `cnt` is cleared on every state entry.
- IDLE:
  - `start`=1 latches wb_base, ub_base, acc_base, num_rows and accumulate.
  - If N=0, go to DONE. Otherwise go to LOAD_W.
  - `start` in any other state is ignored. Inputs are not re-sampled.
- LOAD_W lasts WLOAD_LEN = ARRAY_DIM+1+FIFO_DEPTH cycles (21 at default parameters).
  - weight_fifo_en=1 and mmu_load_weight_en=1 for the whole state.
  - read_wb=1 with addr_rd=wb_base+cnt for cnt < ARRAY_DIM.
- EXEC lasts EXEC_LEN = N+1+FIFO_DEPTH+MMU_LAT cycles (N+36 at default parameters).
  - data_fifo_en=1 and mm_en=1 for the whole state.
  - read_ub=1 with addr_rd=ub_base+cnt for cnt < N.
  - write_acc=1 with addr_wr=acc_base+(cnt−W0) for W0 ≤ cnt < W0+N, where W0 = 1+FIFO_DEPTH+MMU_LAT.
  - acc_en equals the latched accumulate while write_acc=1, and is 0 otherwise.
- DONE lasts one cycle: done=1, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH; base+offset wraps (e.g. 0xFE+3 → 0x01).
- Outside the windows above, every strobe is 0 and addr_rd/addr_wr hold 0.
- `cnt` is ADDR_WIDTH+7 bits wide, so the longest EXEC (N=255) never overflows.

## Timing
- Reset (asynchronous, any state): state=IDLE, cnt=0.
- Every output is 0 while reset is asserted and in the cycle after deassertion.
- All outputs are registered. With `start` sampled at edge 0:
  - LOAD_W occupies cycles 1..WLOAD_LEN.
  - EXEC starts at cycle WLOAD_LEN+1.
  - done appears in the cycle after the last EXEC cycle.
- Total latency from start to done is WLOAD_LEN+EXEC_LEN+1 cycles. For N=0 it is 1 cycle.
- `start` coinciding with the done cycle is ignored. A new request is accepted the cycle after done.
- Reset mid-operation aborts the tile with no completion pulse. Partial accumulator writes are not undone.

## Configuration
- Macro `MMU_SEQ_WEIGHT_REUSE_EN`.
- Defined: adds input port `reuse_w` (1 bit), latched with the other inputs at start.
  - If reuse_w=1 and N≠0, IDLE goes directly to EXEC, skipping LOAD_W, and the MMU keeps its previous weights.
  - Latency becomes EXEC_LEN+1.
- Undefined: no `reuse_w` port, and LOAD_W always executes.

## Test plan
- Reset during EXEC (assert reset_n=0 at cycle 40) -> all outputs 0 immediately; busy=0; no done pulse; the next start runs the full sequence from LOAD_W.
- Basic tile: wb_base=0x10, ub_base=0x20, acc_base=0x30, N=4, accumulate=0, start at cycle 0 ->
  - read_wb cycles 1–16 with addr_rd 0x10–0x1F; LOAD_W strobes cycles 1–21.
  - read_ub cycles 22–25 with addr_rd 0x20–0x23.
  - write_acc cycles 58–61 with addr_wr 0x30–0x33 and acc_en=0.
  - done at cycle 62.
- Wrap and accumulate: ub_base=0xFE, acc_base=0xFF, N=3, accumulate=1 -> addr_rd 0xFE, 0xFF, 0x00; addr_wr 0xFF, 0x00, 0x01; acc_en=1 during each write.
- N=0 -> done one cycle after start; no strobe ever asserted.
- start held high through a 5-row tile -> only one tile executes; done pulses once; the second tile begins the cycle after done.
- With MMU_SEQ_WEIGHT_REUSE_EN and reuse_w=1, N=2 -> no read_wb or mmu_load_weight_en; EXEC begins at cycle 1; done at cycle 39.
